// File: rtl/cpu_sequencer_if.sv
// Signal bundle between cpu_sequencer and the accumulator CPU datapath / UART loader.
// Defining SEQ_SINGLE_STEP_EN adds the step_i input used by the single-step build.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              load_i;
  logic              loadValid_i;
  logic              loadReady_o;
  logic              loadFull_o;
  logic              run_i;
  logic [2:0]        opcode_i;
  logic [ADDR_W-1:0] irAddr_i;
  logic              zero_i;
  logic [ADDR_W-1:0] pc_o;
  logic              imemWe_o;
  logic [ADDR_W-1:0] imemAddr_o;
  logic              irLoad_o;
  logic              memRead_o;
  logic              memWrite_o;
  logic              accLoad_o;
  logic [2:0]        aluOp_o;
  logic              halted_o;
  logic              busy_o;
`ifdef SEQ_SINGLE_STEP_EN
  logic              step_i;
`endif

  modport master (
    input  load_i, loadValid_i, run_i, opcode_i, irAddr_i, zero_i,
`ifdef SEQ_SINGLE_STEP_EN
    input  step_i,
`endif
    output loadReady_o, loadFull_o, pc_o, imemWe_o, imemAddr_o, irLoad_o,
    output memRead_o, memWrite_o, accLoad_o, aluOp_o, halted_o, busy_o
  );

  modport slave (
    output load_i, loadValid_i, run_i, opcode_i, irAddr_i, zero_i,
`ifdef SEQ_SINGLE_STEP_EN
    output step_i,
`endif
    input  loadReady_o, loadFull_o, pc_o, imemWe_o, imemAddr_o, irLoad_o,
    input  memRead_o, memWrite_o, accLoad_o, aluOp_o, halted_o, busy_o
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller and program-load arbiter for the 8-bit accumulator CPU.
// Define SEQ_SINGLE_STEP_EN to add a PAUSE state after each instruction, released by step_i.
module cpu_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0,
  parameter int MEM_LAT  = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  cpu_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [1:0]        LastLat = 2'(MEM_LAT - 1);

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StDecode,
    StExec,
    StHalt
`ifdef SEQ_SINGLE_STEP_EN
    , StPause
`endif
  } state_t;

  state_t            state_q, state_d;
  state_t            execNext;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   loadCount_q, loadCount_d;
  logic [1:0]        latCnt_q, latCnt_d;

  logic              isMemRead;
  logic              loadFull;
  logic              loadReady;
  logic              imemWe;
  logic [ADDR_W-1:0] imemAddr;
  logic              irLoad;
  logic              memRead;
  logic              memWrite;
  logic              accLoad;
  logic [2:0]        aluOp;
  logic              halted;
  logic              busy;

  assign isMemRead = (bus.opcode_i == OpAdd) || (bus.opcode_i == OpAnd) ||
                     (bus.opcode_i == OpXor) || (bus.opcode_i == OpLda);

  // The load counter keeps one extra bit so a full memory is distinguishable from an empty one.
  assign loadFull = loadCount_q[ADDR_W];

  // Load is only honoured at an instruction boundary, so the in-flight instruction always retires.
`ifdef SEQ_SINGLE_STEP_EN
  assign execNext = StPause;
`else
  assign execNext = bus.load_i ? StLoad : StFetch;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pc_q        <= ResetPc;
      loadCount_q <= '0;
      latCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      loadCount_q <= loadCount_d;
      latCnt_q    <= latCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    loadCount_d = loadCount_q;
    latCnt_d    = '0;
    loadReady   = 1'b0;
    imemWe      = 1'b0;
    imemAddr    = pc_q;
    irLoad      = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    accLoad     = 1'b0;
    aluOp       = 3'b000;
    halted      = 1'b0;
    busy        = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.load_i) begin
          state_d = StLoad;
        end else if (bus.run_i) begin
          state_d = StFetch;
        end
      end

      StLoad: begin
        loadReady = ~loadFull;
        imemAddr  = loadCount_q[ADDR_W-1:0];
        imemWe    = bus.loadValid_i & ~loadFull;
        if (imemWe) begin
          loadCount_d = loadCount_q + 1'b1;
        end
        if (!bus.load_i) begin
          state_d     = StIdle;
          pc_d        = ResetPc;
          loadCount_d = '0;
        end
      end

      StFetch: begin
        busy    = 1'b1;
        irLoad  = 1'b1;
        state_d = StDecode;
      end

      StDecode: begin
        busy = 1'b1;
        if (isMemRead) begin
          memRead = 1'b1;
          if (latCnt_q == LastLat) begin
            state_d = StExec;
          end else begin
            latCnt_d = latCnt_q + 2'd1;
          end
        end else begin
          state_d = StExec;
        end
      end

      StExec: begin
        busy    = 1'b1;
        aluOp   = bus.opcode_i;
        state_d = execNext;
        case (bus.opcode_i)
          OpHlt: state_d = StHalt;
          OpSkz: pc_d = bus.zero_i ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);
          OpSto: begin
            memWrite = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
          end
          OpJmp: pc_d = bus.irAddr_i;
          default: begin
            accLoad = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
          end
        endcase
      end

      StHalt: begin
        halted = 1'b1;
        if (bus.load_i) begin
          state_d = StLoad;
        end else if (bus.run_i) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end

`ifdef SEQ_SINGLE_STEP_EN
      StPause: begin
        if (bus.load_i) begin
          state_d = StLoad;
        end else if (bus.step_i) begin
          state_d = StFetch;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  assign bus.loadReady_o = loadReady;
  assign bus.loadFull_o  = loadFull;
  assign bus.pc_o        = pc_q;
  assign bus.imemWe_o    = imemWe;
  assign bus.imemAddr_o  = imemAddr;
  assign bus.irLoad_o    = irLoad;
  assign bus.memRead_o   = memRead;
  assign bus.memWrite_o  = memWrite;
  assign bus.accLoad_o   = accLoad;
  assign bus.aluOp_o     = aluOp;
  assign bus.halted_o    = halted;
  assign bus.busy_o      = busy;

  // Data-moving strobes share buses downstream and must never overlap.
  strobeOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({irLoad, memWrite, accLoad, imemWe}));

  busyNotHalted: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(busy && halted));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: loads random programs over the loader port and checks
// each instruction against an instruction-level model of the accumulator CPU.
module tb_cpu_sequencer;

  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 32;
  localparam int MEM_LAT  = 3;
  localparam int RESET_PC = 0;

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  cpu_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_sequencer #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk_i (clock),
    .rst_ni(resetN),
    .bus   (bus)
  );

  int checks      = 0;
  int passes      = 0;
  int multiStrobe = 0;

  logic [7:0] imemEnv    [DEPTH];
  logic [7:0] dmemEnv    [DEPTH];
  logic [7:0] presetDmem [DEPTH];
  logic [7:0] progImage  [DEPTH];
  logic [7:0] mDmem      [DEPTH];
  logic [7:0] irEnv;
  logic [7:0] accEnv;
  logic [7:0] presetAcc;
  logic [7:0] mAcc;
  logic [7:0] uartByte;
  logic       presetReq;

  // Stand-in datapath: instruction/data memories, IR and accumulator driven by the sequencer strobes.
  assign bus.opcode_i = irEnv[7:5];
  assign bus.irAddr_i = irEnv[4:0];
  assign bus.zero_i   = (accEnv == 8'd0);

`ifdef SEQ_SINGLE_STEP_EN
  assign bus.step_i = 1'b1;
`endif

  always @(posedge clock) begin
    if (bus.imemWe_o) imemEnv[bus.imemAddr_o] <= uartByte;
    if (bus.irLoad_o) irEnv <= imemEnv[bus.imemAddr_o];
    if (presetReq) begin
      accEnv <= presetAcc;
      for (int i = 0; i < DEPTH; i++) dmemEnv[i] <= presetDmem[i];
    end else begin
      if (bus.accLoad_o) begin
        case (bus.aluOp_o)
          3'd2:    accEnv <= accEnv + dmemEnv[bus.irAddr_i];
          3'd3:    accEnv <= accEnv & dmemEnv[bus.irAddr_i];
          3'd4:    accEnv <= accEnv ^ dmemEnv[bus.irAddr_i];
          3'd5:    accEnv <= dmemEnv[bus.irAddr_i];
          default: accEnv <= ~accEnv;
        endcase
      end
      if (bus.memWrite_o) dmemEnv[bus.irAddr_i] <= accEnv;
    end
  end

  // Counts cycles where more than one data-moving strobe fires together.
  always @(posedge clock) begin
    if (resetN && ($countones({bus.irLoad_o, bus.memWrite_o, bus.accLoad_o, bus.imemWe_o}) > 1))
      multiStrobe <= multiStrobe + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic bit isReadOp(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

  // Instruction-level next PC: SKZ skips on zero, JMP is absolute, HLT stays put.
  function automatic int modelNextPc(input logic [2:0] op, input int a, input int pc, input logic [7:0] acc);
    case (op)
      3'd0:    return pc;
      3'd1:    return (acc == 8'd0) ? (pc + 2) % DEPTH : (pc + 1) % DEPTH;
      3'd7:    return a;
      default: return (pc + 1) % DEPTH;
    endcase
  endfunction

  task automatic genRandomProgram();
    for (int i = 0; i < DEPTH; i++) progImage[i] = 8'($urandom);
    if (progImage[0][7:5] == 3'd0) progImage[0][7:5] = 3'd5;
  endtask

  task automatic presetEnv(input logic [7:0] acc);
    presetAcc = acc;
    mAcc      = acc;
    for (int i = 0; i < DEPTH; i++) begin
      presetDmem[i] = 8'($urandom);
      mDmem[i]      = presetDmem[i];
    end
    presetReq = 1'b1;
    nextCycle();
    presetReq = 1'b0;
  endtask

  task automatic loadProgram(input bit inLoad);
    int sent  = 0;
    int errs  = 0;
    int guard = 0;
    int mism  = 0;
    bit valid;
    if (!inLoad) begin
      bus.load_i = 1'b1;
      nextCycle();
    end
    checkOutput("loadReady", 32'(bus.loadReady_o), 1);
    while (sent < DEPTH && guard < 400) begin
      valid           = ($urandom_range(0, 3) != 0);
      bus.loadValid_i = valid;
      uartByte        = progImage[sent];
      #1;
      if (valid) begin
        if (!bus.imemWe_o || int'(bus.imemAddr_o) != sent) errs++;
        sent++;
      end else if (bus.imemWe_o) begin
        errs++;
      end
      nextCycle();
      guard++;
    end
    bus.loadValid_i = 1'b0;
    checkOutput("loadSent", 32'(sent), DEPTH);
    checkOutput("loadWeAddr", 32'(errs), 0);
    checkOutput("loadFullFlags", 32'({bus.loadFull_o, bus.loadReady_o}), 32'b10);
    bus.loadValid_i = 1'b1;
    uartByte        = 8'h5A;
    #1;
    checkOutput("overflowWe", 32'(bus.imemWe_o), 0);
    nextCycle();
    bus.loadValid_i = 1'b0;
    bus.load_i      = 1'b0;
    nextCycle();
    checkOutput("loadExitPc", 32'(bus.pc_o), RESET_PC);
    checkOutput("loadExitFlags", 32'({bus.loadFull_o, bus.loadReady_o, bus.busy_o, bus.halted_o}), 0);
    for (int i = 0; i < DEPTH; i++) if (imemEnv[i] !== progImage[i]) mism++;
    checkOutput("imemImage", 32'(mism), 0);
  endtask

  task automatic runProgram(input int maxFetches, input bit resume, output bit endedHalted);
    int mPc = RESET_PC;
    int a, len, nextPc, memReadCnt, busyCnt, stray, mism;
    logic [2:0] op;
    bit isRead;
    endedHalted = 1'b0;
    bus.run_i = 1'b1;
    nextCycle();
    bus.run_i = 1'b0;
    for (int n = 0; n < maxFetches; n++) begin
      op     = progImage[mPc][7:5];
      a      = int'(progImage[mPc][4:0]);
      isRead = isReadOp(op);
      len    = isRead ? MEM_LAT + 2 : 3;
      nextPc = modelNextPc(op, a, mPc, mAcc);
      checkOutput("fetchIrLoad", 32'(bus.irLoad_o), 1);
      checkOutput("fetchPc", 32'(bus.pc_o), 32'(mPc));
      checkOutput("fetchAddr", 32'(bus.imemAddr_o), 32'(mPc));
      case (op)
        3'd2: mAcc = mAcc + mDmem[a];
        3'd3: mAcc = mAcc & mDmem[a];
        3'd4: mAcc = mAcc ^ mDmem[a];
        3'd5: mAcc = mDmem[a];
        3'd6: mDmem[a] = mAcc;
        default: ;
      endcase
      memReadCnt = 0;
      busyCnt    = 0;
      stray      = 0;
      for (int c = 0; c < len; c++) begin
        if (c > 0) begin
          nextCycle();
          if (bus.irLoad_o || bus.halted_o) stray++;
        end
        if (bus.memRead_o) memReadCnt++;
        if (bus.busy_o) busyCnt++;
        if (c < len - 1 && (bus.accLoad_o || bus.memWrite_o)) stray++;
        if (c == len - 1)
          checkOutput("execStrobes", 32'({bus.accLoad_o, bus.memWrite_o, bus.aluOp_o}),
                      32'({isRead, op == 3'd6, op}));
      end
      checkOutput("decodeMemRead", 32'(memReadCnt), isRead ? MEM_LAT : 0);
      checkOutput("busyCycles", 32'(busyCnt), 32'(len));
      checkOutput("strayStrobes", 32'(stray), 0);
      nextCycle();
`ifdef SEQ_SINGLE_STEP_EN
      if (op != 3'd0) begin
        checkOutput("pauseBusy", 32'({bus.busy_o, bus.irLoad_o}), 0);
        nextCycle();
      end
`endif
      if (op == 3'd0) begin
        checkOutput("halted", 32'(bus.halted_o), 1);
        checkOutput("haltPc", 32'(bus.pc_o), 32'(mPc));
        if (!resume || n == maxFetches - 1) begin
          endedHalted = 1'b1;
          break;
        end
        bus.run_i = 1'b1;
        nextCycle();
        bus.run_i = 1'b0;
        mPc = (mPc + 1) % DEPTH;
      end else begin
        mPc = nextPc;
      end
    end
    checkOutput("accResult", 32'(accEnv), 32'(mAcc));
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (dmemEnv[i] !== mDmem[i]) mism++;
    checkOutput("dmemResult", 32'(mism), 0);
  endtask

  task automatic applyReset(input int advance, input bit expectStoExec);
    repeat (advance) nextCycle();
    if (expectStoExec) checkOutput("preResetMemWrite", 32'(bus.memWrite_o), 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("resetStrobes", 32'({bus.irLoad_o, bus.memRead_o, bus.memWrite_o, bus.accLoad_o,
                                     bus.imemWe_o, bus.loadReady_o, bus.loadFull_o, bus.halted_o,
                                     bus.busy_o}), 0);
    checkOutput("resetPc", 32'(bus.pc_o), RESET_PC);
    checkOutput("resetImemAddr", 32'(bus.imemAddr_o), RESET_PC);
    checkOutput("resetAluOp", 32'(bus.aluOp_o), 0);
    nextCycle();
    resetN = 1'b1;
    nextCycle();
  endtask

  task automatic loadInterrupt();
    logic [2:0] op;
    int a, len, nextPc;
    bus.run_i = 1'b1;
    nextCycle();
    bus.run_i = 1'b0;
    op     = progImage[0][7:5];
    a      = int'(progImage[0][4:0]);
    len    = isReadOp(op) ? MEM_LAT + 2 : 3;
    nextPc = modelNextPc(op, a, RESET_PC, mAcc);
    checkOutput("intrFetch", 32'(bus.irLoad_o), 1);
    nextCycle();
    bus.load_i = 1'b1;
    repeat (len - 1) nextCycle();
`ifdef SEQ_SINGLE_STEP_EN
    nextCycle();
`endif
    checkOutput("intrLoadState", 32'({bus.irLoad_o, bus.loadReady_o}), 32'b01);
    checkOutput("intrPc", 32'(bus.pc_o), 32'(nextPc));
    genRandomProgram();
    loadProgram(1'b1);
  endtask

  // Builds one scenario: program image, loader transfer, datapath preset and a bounded run.
  task automatic applyStimulus(input int kind);
    bit halted;
    genRandomProgram();
    case (kind)
      0: begin
        progImage[0] = 8'hA5;
        progImage[1] = 8'h46;
        progImage[2] = 8'hC7;
        progImage[3] = 8'h00;
      end
      1, 2: begin
        progImage[0]  = 8'hFF;
        progImage[31] = 8'h20;
        progImage[1]  = 8'h00;
      end
      3: begin
        progImage[0]  = 8'hFA;
        progImage[26] = 8'hFE;
        progImage[30] = 8'h20;
      end
      4: begin
        progImage[0] = 8'hC9;
        progImage[1] = 8'hE0;
      end
      default: ;
    endcase
    loadProgram(1'b0);
    case (kind)
      1, 3:    presetEnv(8'h00);
      2:       presetEnv(8'h40);
      default: presetEnv(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    endcase
    case (kind)
      0:       runProgram(4, 1'b0, halted);
      1:       runProgram(3, 1'b0, halted);
      2:       runProgram(5, 1'b0, halted);
      3:       runProgram(4, 1'b0, halted);
      4:       runProgram(2, 1'b0, halted);
      default: runProgram(25, 1'b1, halted);
    endcase
    if (kind == 0 || kind == 1) checkOutput("directedHalt", 32'(halted), 1);
    if (kind == 4) applyReset(2, 1'b1);
    else if (!halted) applyReset($urandom_range(0, 4), 1'b0);
  endtask

  initial begin
    resetN          = 1'b0;
    bus.load_i      = 1'b0;
    bus.loadValid_i = 1'b0;
    bus.run_i       = 1'b0;
    uartByte        = 8'h00;
    presetReq       = 1'b0;
    presetAcc       = 8'h00;
    #3;
    checkOutput("initStrobes", 32'({bus.irLoad_o, bus.memWrite_o, bus.accLoad_o, bus.imemWe_o,
                                    bus.busy_o, bus.halted_o}), 0);
    checkOutput("initImemAddr", 32'(bus.imemAddr_o), RESET_PC);
    repeat (2) @(posedge clock);
    #1 resetN = 1'b1;
    nextCycle();
    checkOutput("idlePc", 32'(bus.pc_o), RESET_PC);
    checkOutput("idleFlags", 32'({bus.busy_o, bus.halted_o, bus.loadReady_o}), 0);

    for (int k = 0; k < 5; k++) applyStimulus(k);

    genRandomProgram();
    loadProgram(1'b0);
    presetEnv(8'($urandom));
    loadInterrupt();

    for (int k = 0; k < 8; k++) applyStimulus(10 + k);

    checkOutput("strobeOverlap", 32'(multiStrobe), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
